// File: rtl/serial_add_sub_ctrl.sv
// serial_add_sub_ctrl
//
// Bit-serial WIDTH-bit adder/subtractor controller. It latches two operands and
// an op select. It then steps a single 1-bit full-adder cell once per clock,
// LSB first, for WIDTH cycles. The cell is two half-adder stages plus an OR.
// Sum bits are collected in a shift register. Completion is signalled with a
// one-cycle done pulse. Subtraction is a + ~b + 1: the B operand is inverted
// at load time and the carry starts at 1.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous, active-high reset (discards any in-flight operation)
//   start   request, sampled only while busy = 0
//   op      0 = add (a + b), 1 = subtract (a - b), sampled with start
//   a, b    WIDTH-bit operands, sampled with start
//   busy    high while a computation is in progress
//   done    one-cycle pulse when result/cout/ovf are valid
//   result  WIDTH-bit sum/difference, held until the next completion
//   cout    add: carry out; subtract: borrow (1 when a < b, unsigned)
//   ovf     signed two's-complement overflow
module serial_add_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] acc_sr;
    logic [CNT_W-1:0] bit_cnt;
    logic             carry;
    logic             op_r;

    logic [1:0]       ha1;        // {carry, sum} of a0 + b0
    logic [1:0]       ha2;        // {carry, sum} of (a0 ^ b0) + carry
    logic             sum_bit;
    logic             carry_nxt;
    logic             last_bit;
    logic             accept;

    // Half adder, returned as {carry, sum}.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // Shared 1-bit full-adder cell.
    always_comb begin
        ha1       = half_add(a_sr[0], b_sr[0]);
        ha2       = half_add(ha1[0], carry);
        sum_bit   = ha2[0];
        carry_nxt = ha1[1] | ha2[1];
    end

    assign last_bit = (bit_cnt == LAST_BIT);
    assign accept   = start && (state != RUN);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                // Back-to-back request goes straight to RUN with no IDLE gap.
                state_nxt = start ? RUN : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Serial datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            acc_sr  <= '0;
            bit_cnt <= '0;
            carry   <= 1'b0;
            op_r    <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            a_sr    <= a;
            b_sr    <= op ? ~b : b;
            op_r    <= op;
            carry   <= op;          // +1 of the two's-complement negate
            bit_cnt <= '0;
        end else if (state == RUN) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            acc_sr  <= {sum_bit, acc_sr[WIDTH-1:1]};
            carry   <= carry_nxt;
            bit_cnt <= bit_cnt + 1'b1;
            if (last_bit) begin
                result <= {sum_bit, acc_sr[WIDTH-1:1]};
                // Subtract reports borrow, which is the inverted final carry.
                cout   <= op_r ? ~carry_nxt : carry_nxt;
                // Carry into the MSB differs from carry out of it on overflow.
                ovf    <= carry ^ carry_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
module tb_serial_add_sub_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    int tests    = 0;
    int fails    = 0;
    int cyc      = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    serial_add_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"},   32'(busy),   32'd0);
        chk({tag, " done"},   32'(done),   32'd0);
        chk({tag, " result"}, 32'(result), 32'd0);
        chk({tag, " cout"},   32'(cout),   32'd0);
        chk({tag, " ovf"},    32'(ovf),    32'd0);
    endtask

    task automatic idle_step(input string tag);
        @(posedge clk); #1;
        chk({tag, " idle done"}, 32'(done), 32'd0);
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
    endtask

    // Issues one request and follows it to the done cycle. Returns at #1 after
    // the completing edge, i.e. inside the DONE cycle.
    task automatic run_op(input string tag, input logic o,
                          input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                          input logic [WIDTH-1:0] er, input logic ec, input logic eo,
                          input bit repulse, output int dcyc);
        logic [WIDTH-1:0] prev;
        int               scyc;
        bit               bad;
        prev  = result;
        bad   = 1'b0;
        op    = o;
        a     = xa;
        b     = xb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scyc  = cyc;
        chk({tag, " busy@E0"}, 32'(busy), 32'd1);
        chk({tag, " done@E0"}, 32'(done), 32'd0);
        for (int i = 1; i <= WIDTH; i++) begin
            if (repulse && i == 3) begin
                start = 1'b1;
                op    = ~o;
                a     = ~xa;
                b     = ~xb;
            end
            if (repulse && i == 5) start = 1'b0;
            @(posedge clk); #1;
            if (i < WIDTH) begin
                if (busy !== 1'b1 || done !== 1'b0 || result !== prev) bad = 1'b1;
            end
        end
        dcyc = cyc;
        chk({tag, " run-hold"}, 32'(bad),         32'd0);
        chk({tag, " done"},     32'(done),        32'd1);
        chk({tag, " busy"},     32'(busy),        32'd0);
        chk({tag, " result"},   32'(result),      32'(er));
        chk({tag, " cout"},     32'(cout),        32'(ec));
        chk({tag, " ovf"},      32'(ovf),         32'(eo));
        chk({tag, " latency"},  32'(dcyc - scyc), 32'(WIDTH));
    endtask

    // Reference: {ovf, cout, result} computed at WIDTH+1 bits.
    function automatic logic [WIDTH+1:0] model(input logic o, input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] res;
        logic             v;
        full = o ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
        res  = full[WIDTH-1:0];
        if (o) v = (x[WIDTH-1] != y[WIDTH-1]) && (res[WIDTH-1] != x[WIDTH-1]);
        else   v = (x[WIDTH-1] == y[WIDTH-1]) && (res[WIDTH-1] != x[WIDTH-1]);
        return {v, full[WIDTH], res};
    endfunction

    initial begin
        int               dc1;
        int               dc2;
        int               d0;
        logic             ro;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [WIDTH+1:0] exp_v;

        rst   = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        #2 rst = 1'b1;
        #20;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        idle_step("post-reset");

        // Directed arithmetic cases, each followed by an idle cycle.
        run_op("add 5A+3C", 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b1 ^ 1'b1, 1'b1, 1'b0, dc1);
        idle_step("after 5A+3C");
        run_op("add FF+01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, dc1);
        idle_step("after FF+01");
        run_op("add 00+00", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, dc1);
        idle_step("after 00+00");
        run_op("sub 10-20", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0, dc1);
        idle_step("after 10-20");
        run_op("sub 80-01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, dc1);
        idle_step("after 80-01");

        // Start re-pulsed mid-RUN is ignored; then a back-to-back request.
        d0 = done_cnt;
        run_op("repulse 5A+3C", 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1, 1'b1, dc1);
        run_op("b2b sub 80-01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, dc2);
        chk("b2b done spacing", 32'(dc2 - dc1), 32'(WIDTH + 1));
        idle_step("after b2b");
        chk("repulse+b2b done count", 32'(done_cnt - d0), 32'd2);

        // Asynchronous reset in the middle of RUN.
        op    = 1'b0;
        a     = 8'h5A;
        b     = 8'h3C;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_zero("mid-run reset");
        #2 rst = 1'b0;
        d0 = done_cnt;
        repeat (WIDTH + 2) @(posedge clk);
        #1;
        chk("no done after reset", 32'(done_cnt - d0), 32'd0);
        chk("idle after reset", 32'(busy), 32'd0);
        run_op("add 01+02", 1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0, dc1);
        idle_step("after 01+02");

        // Randomized sweep against the WIDTH+1-bit reference.
        for (int n = 0; n < 200; n++) begin
            ro    = 1'($urandom_range(0, 1));
            ra    = WIDTH'($urandom);
            rb    = WIDTH'($urandom);
            exp_v = model(ro, ra, rb);
            run_op("random", ro, ra, rb, exp_v[WIDTH-1:0], exp_v[WIDTH], exp_v[WIDTH+1],
                   1'b0, dc1);
            if ((n % 4) == 3) idle_step("random gap");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
